// File: rtl/cva6_axi_rd_arbiter.sv
// ----------------------------------------------------------------------------
// cva6_axi_rd_arbiter
//
// Shares the single read port of one axi_shim between NumPorts cache refill
// requesters (port 0 = L1I$ refill, port 1 = L1D$/bypass reads). Each port
// gets a one-entry request slot. Slots are issued round-robin to the shim.
// The AXI ID of each read carries the port index in its MSBs, and returning
// R beats are routed back to the owning port by that field.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   req_i / ack_o            per-port request, accepted when ack_o is high
//   addr_i, blen_i, size_i,  per-port request fields, packed port-major
//   tid_i
//   rtrn_valid_o             per-port return beat strobe
//   rtrn_last_o, rtrn_data_o, rtrn_tid_o, rtrn_exokay_o  shared beat fields
//   rd_req_o / rd_gnt_i      request to the shim and its grant
//   rd_addr_o, rd_blen_o, rd_size_o, rd_id_o  fields of the offered request
//   rd_rdy_o                 always ready for R beats
//   rd_valid_i, rd_last_i, rd_data_i, rd_id_i, rd_exokay_i  R beat from shim
//   err_o                    sticky: beat for an unknown port or with no
//                            burst outstanding on that port
//
// Handshakes:
//   requester side: a request transfers in the cycle where req_i[p] and
//   ack_o[p] are both high. ack_o is combinational; if it is low the
//   requester keeps req_i and its fields unchanged.
//   shim side: rd_req_o/rd_gnt_i follow AXI valid/ready rules. Once rd_req_o
//   is raised, it and all rd_* fields stay stable until the grant cycle.
//   R beats are always accepted (rd_rdy_o = 1).
// ----------------------------------------------------------------------------
module cva6_axi_rd_arbiter #(
    parameter int unsigned NumPorts       = 2,
    parameter int unsigned IdWidth        = 4,
    parameter int unsigned AddrWidth      = 64,
    parameter int unsigned BlenWidth      = 2,
    parameter int unsigned MaxOutstanding = 4,
    localparam int unsigned PortBits      = (NumPorts > 1) ? $clog2(NumPorts) : 1,
    localparam int unsigned TidWidth      = IdWidth - PortBits,
    localparam int unsigned CntWidth      = $clog2(MaxOutstanding + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumPorts-1:0]           req_i,
    output logic [NumPorts-1:0]           ack_o,
    input  logic [NumPorts*AddrWidth-1:0] addr_i,
    input  logic [NumPorts*BlenWidth-1:0] blen_i,
    input  logic [NumPorts*2-1:0]         size_i,
    input  logic [NumPorts*TidWidth-1:0]  tid_i,
    output logic [NumPorts-1:0]           rtrn_valid_o,
    output logic                          rtrn_last_o,
    output logic [63:0]                   rtrn_data_o,
    output logic [TidWidth-1:0]           rtrn_tid_o,
    output logic                          rtrn_exokay_o,
    output logic                          rd_req_o,
    input  logic                          rd_gnt_i,
    output logic [AddrWidth-1:0]          rd_addr_o,
    output logic [BlenWidth-1:0]          rd_blen_o,
    output logic [1:0]                    rd_size_o,
    output logic [IdWidth-1:0]            rd_id_o,
    output logic                          rd_rdy_o,
    input  logic                          rd_valid_i,
    input  logic                          rd_last_i,
    input  logic [63:0]                   rd_data_i,
    input  logic [IdWidth-1:0]            rd_id_i,
    input  logic                          rd_exokay_i,
    output logic                          err_o
);

    // Per-port request slots
    logic [NumPorts-1:0]  pend_q;
    logic [AddrWidth-1:0] slot_addr_q [NumPorts];
    logic [BlenWidth-1:0] slot_blen_q [NumPorts];
    logic [1:0]           slot_size_q [NumPorts];
    logic [TidWidth-1:0]  slot_tid_q  [NumPorts];
    logic [CntWidth-1:0]  outst_q     [NumPorts];

    // Arbitration state
    logic [PortBits-1:0]  rr_q;
    logic [PortBits-1:0]  sel_q;
    logic                 lock_q;
    logic                 err_q;

    logic [PortBits-1:0]  arb_sel;
    logic [PortBits-1:0]  scan_idx;
    logic                 found;
    logic [PortBits-1:0]  sel;
    logic                 grant;
    logic [PortBits-1:0]  rtrn_port;
    logic                 beat_err;

    // Accept: one slot per port, and no new burst once the port has the
    // maximum number of bursts in flight (this also keeps outst_q from wrapping).
    always_comb begin
        for (int i = 0; i < NumPorts; i++) begin
            ack_o[i] = req_i[i] & ~pend_q[i] & (outst_q[i] < CntWidth'(MaxOutstanding));
        end
    end

    // Round-robin scan: first pending port at or after rr_q.
    always_comb begin
        arb_sel  = '0;
        scan_idx = '0;
        found    = 1'b0;
        for (int k = 0; k < NumPorts; k++) begin
            scan_idx = PortBits'((int'(rr_q) + k) % NumPorts);
            if (!found && pend_q[scan_idx]) begin
                found   = 1'b1;
                arb_sel = scan_idx;
            end
        end
    end

    // While an offer is waiting for its grant, keep offering the same port,
    // even if a port with higher round-robin priority becomes pending.
    assign sel   = lock_q ? sel_q : arb_sel;
    assign grant = rd_req_o & rd_gnt_i;

    assign rd_req_o  = |pend_q;
    assign rd_addr_o = slot_addr_q[sel];
    assign rd_blen_o = slot_blen_q[sel];
    assign rd_size_o = slot_size_q[sel];
    assign rd_id_o   = {sel, slot_tid_q[sel]};
    assign rd_rdy_o  = 1'b1;

    // Return routing. A beat is only delivered to a port that exists and has
    // a burst in flight; anything else is dropped and flagged.
    assign rtrn_port = rd_id_i[IdWidth-1 -: PortBits];

    always_comb begin
        rtrn_valid_o = '0;
        for (int i = 0; i < NumPorts; i++) begin
            if (rd_valid_i && (rtrn_port == PortBits'(i)) && (outst_q[i] != '0)) begin
                rtrn_valid_o[i] = 1'b1;
            end
        end
    end

    assign beat_err      = rd_valid_i & ~(|rtrn_valid_o);
    assign rtrn_last_o   = rd_last_i;
    assign rtrn_data_o   = rd_data_i;
    assign rtrn_tid_o    = rd_id_i[TidWidth-1:0];
    assign rtrn_exokay_o = rd_exokay_i;
    assign err_o         = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q <= '0;
            rr_q   <= '0;
            sel_q  <= '0;
            lock_q <= 1'b0;
            err_q  <= 1'b0;
            for (int i = 0; i < NumPorts; i++) begin
                slot_addr_q[i] <= '0;
                slot_blen_q[i] <= '0;
                slot_size_q[i] <= '0;
                slot_tid_q[i]  <= '0;
                outst_q[i]     <= '0;
            end
        end else begin
            lock_q <= rd_req_o & ~rd_gnt_i;
            sel_q  <= sel;
            if (beat_err) begin
                err_q <= 1'b1;
            end
            if (grant) begin
                rr_q <= (sel == PortBits'(NumPorts - 1)) ? '0 : sel + 1'b1;
            end
            for (int i = 0; i < NumPorts; i++) begin
                // Grant and ack never hit the same port in one cycle: ack
                // needs an empty slot, grant needs a full one.
                if (grant && (sel == PortBits'(i))) begin
                    pend_q[i] <= 1'b0;
                end
                if (ack_o[i]) begin
                    pend_q[i]      <= 1'b1;
                    slot_addr_q[i] <= addr_i[i*AddrWidth +: AddrWidth];
                    slot_blen_q[i] <= blen_i[i*BlenWidth +: BlenWidth];
                    slot_size_q[i] <= size_i[i*2 +: 2];
                    slot_tid_q[i]  <= tid_i[i*TidWidth +: TidWidth];
                end
                // A grant and a last beat on the same port cancel out.
                case ({grant && (sel == PortBits'(i)), rtrn_valid_o[i] && rd_last_i})
                    2'b10:   outst_q[i] <= outst_q[i] + 1'b1;
                    2'b01:   outst_q[i] <= outst_q[i] - 1'b1;
                    default: outst_q[i] <= outst_q[i];
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cva6_axi_rd_arbiter.sv
module tb_cva6_axi_rd_arbiter;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]   req;
    logic [1:0]   ack;
    logic [127:0] addr;
    logic [3:0]   blen;
    logic [3:0]   size;
    logic [5:0]   tid;
    logic [1:0]   rtrn_valid;
    logic         rtrn_last;
    logic [63:0]  rtrn_data;
    logic [2:0]   rtrn_tid;
    logic         rtrn_exokay;
    logic         rd_req;
    logic         rd_gnt;
    logic [63:0]  rd_addr;
    logic [1:0]   rd_blen;
    logic [1:0]   rd_size;
    logic [3:0]   rd_id;
    logic         rd_rdy;
    logic         rd_valid;
    logic         rd_last;
    logic [63:0]  rd_data;
    logic [3:0]   rd_id_in;
    logic         rd_exokay;
    logic         err;

    int errors = 0;
    int checks = 0;

    cva6_axi_rd_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_i(req), .ack_o(ack), .addr_i(addr), .blen_i(blen), .size_i(size), .tid_i(tid),
        .rtrn_valid_o(rtrn_valid), .rtrn_last_o(rtrn_last), .rtrn_data_o(rtrn_data),
        .rtrn_tid_o(rtrn_tid), .rtrn_exokay_o(rtrn_exokay),
        .rd_req_o(rd_req), .rd_gnt_i(rd_gnt), .rd_addr_o(rd_addr), .rd_blen_o(rd_blen),
        .rd_size_o(rd_size), .rd_id_o(rd_id), .rd_rdy_o(rd_rdy),
        .rd_valid_i(rd_valid), .rd_last_i(rd_last), .rd_data_i(rd_data), .rd_id_i(rd_id_in),
        .rd_exokay_i(rd_exokay), .err_o(err)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks (all start and end just after a negedge) ----------------
    task automatic set_fields(input int p, input logic [63:0] a, input logic [2:0] t, input logic [1:0] b);
        addr[p*64 +: 64] = a;
        tid[p*3 +: 3]    = t;
        blen[p*2 +: 2]   = b;
        size[p*2 +: 2]   = 2'b11;
    endtask

    task automatic idle_inputs();
        req = '0; rd_gnt = 1'b0; rd_valid = 1'b0; rd_last = 1'b0;
        rd_data = '0; rd_id_in = '0; rd_exokay = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_req(input int p, input logic [63:0] a, input logic [2:0] t,
                             input logic [1:0] b, output logic acked);
        set_fields(p, a, t, b);
        req[p] = 1'b1;
        #1 acked = ack[p];
        @(posedge clk);
        @(negedge clk);
        req[p] = 1'b0;
    endtask

    task automatic grant_one(output logic seen, output logic [3:0] id, output logic [63:0] a);
        rd_gnt = 1'b1;
        #1 seen = rd_req; id = rd_id; a = rd_addr;
        @(posedge clk);
        @(negedge clk);
        rd_gnt = 1'b0;
    endtask

    task automatic send_beat(input logic [3:0] id, input logic last, input logic [63:0] d,
                             output logic [1:0] rv, output logic [2:0] rt, output logic rl,
                             output logic [63:0] rdat);
        rd_valid = 1'b1; rd_id_in = id; rd_last = last; rd_data = d;
        #1 rv = rtrn_valid; rt = rtrn_tid; rl = rtrn_last; rdat = rtrn_data;
        @(posedge clk);
        @(negedge clk);
        rd_valid = 1'b0; rd_last = 1'b0;
    endtask

    // ---------------- directed tests ----------------
    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL reset_rd_req: got %b want 0", rd_req); end
        checks++; if (ack !== 2'b00) begin errors++; $display("FAIL reset_ack: got %b want 00", ack); end
        checks++; if (rtrn_valid !== 2'b00) begin errors++; $display("FAIL reset_rtrn_valid: got %b want 00", rtrn_valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (rd_rdy !== 1'b1) begin errors++; $display("FAIL reset_rd_rdy: got %b want 1", rd_rdy); end
        @(negedge clk);
    endtask

    task automatic test_single();
        logic a, seen, rl; logic [3:0] id; logic [63:0] ad, rdat; logic [1:0] rv; logic [2:0] rt;
        do_reset();
        pulse_req(0, 64'h8000_0000, 3'd0, 2'd1, a);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL single_ack: got %b want 1", a); end
        grant_one(seen, id, ad);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL single_req_latency: got %b want 1", seen); end
        checks++; if (id !== 4'h0) begin errors++; $display("FAIL single_id: got %h want 0", id); end
        checks++; if (ad !== 64'h8000_0000) begin errors++; $display("FAIL single_addr: got %h want 80000000", ad); end
        checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL single_req_drop: got %b want 0", rd_req); end
        send_beat(4'h0, 1'b0, 64'h1111_2222_3333_4444, rv, rt, rl, rdat);
        checks++; if (rv !== 2'b01 || rl !== 1'b0) begin errors++; $display("FAIL single_beat1: got rv=%b last=%b want 01/0", rv, rl); end
        checks++; if (rdat !== 64'h1111_2222_3333_4444) begin errors++; $display("FAIL single_data: got %h", rdat); end
        send_beat(4'h0, 1'b1, 64'h5555_6666_7777_8888, rv, rt, rl, rdat);
        checks++; if (rv !== 2'b01 || rl !== 1'b1) begin errors++; $display("FAIL single_beat2: got rv=%b last=%b want 01/1", rv, rl); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL single_err: got %b want 0", err); end
    endtask

    task automatic test_round_robin();
        logic a, seen; logic [1:0] a2; logic [3:0] id; logic [63:0] ad;
        do_reset();
        set_fields(0, 64'hA000, 3'd2, 2'd0);
        set_fields(1, 64'hB000, 3'd5, 2'd0);
        req = 2'b11;
        #1 a2 = ack;
        @(posedge clk); @(negedge clk); req = 2'b00;
        checks++; if (a2 !== 2'b11) begin errors++; $display("FAIL rr_pair_ack: got %b want 11", a2); end
        grant_one(seen, id, ad);
        checks++; if (id !== 4'h2 || ad !== 64'hA000) begin errors++; $display("FAIL rr_first: got id=%h addr=%h want 2/a000", id, ad); end
        grant_one(seen, id, ad);
        checks++; if (id !== 4'hD || ad !== 64'hB000) begin errors++; $display("FAIL rr_second: got id=%h addr=%h want d/b000", id, ad); end
        // a lone port-0 grant moves the pointer to port 1
        pulse_req(0, 64'hA100, 3'd1, 2'd0, a);
        grant_one(seen, id, ad);
        checks++; if (id !== 4'h1) begin errors++; $display("FAIL rr_single: got id=%h want 1", id); end
        set_fields(0, 64'hA200, 3'd4, 2'd0);
        set_fields(1, 64'hB200, 3'd0, 2'd0);
        req = 2'b11;
        @(posedge clk); @(negedge clk); req = 2'b00;
        grant_one(seen, id, ad);
        checks++; if (id !== 4'h8 || ad !== 64'hB200) begin errors++; $display("FAIL rr_pair2_first: got id=%h addr=%h want 8/b200", id, ad); end
        grant_one(seen, id, ad);
        checks++; if (id !== 4'h4 || ad !== 64'hA200) begin errors++; $display("FAIL rr_pair2_second: got id=%h addr=%h want 4/a200", id, ad); end
    endtask

    task automatic test_lock();
        logic a, seen; logic [3:0] id; logic [63:0] ad;
        do_reset();
        pulse_req(0, 64'hC000, 3'd1, 2'd0, a);
        grant_one(seen, id, ad);           // pointer now favours port 1
        pulse_req(0, 64'hC100, 3'd3, 2'd0, a);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                set_fields(1, 64'hD100, 3'd6, 2'd0);
                req[1] = 1'b1;
            end
            #1;
            if (i == 1) begin
                checks++; if (ack[1] !== 1'b1) begin errors++; $display("FAIL lock_p1_ack: got %b want 1", ack[1]); end
            end
            checks++; if (rd_req !== 1'b1 || rd_addr !== 64'hC100 || rd_id !== 4'h3)
                begin errors++; $display("FAIL lock_stable[%0d]: got req=%b addr=%h id=%h want 1/c100/3", i, rd_req, rd_addr, rd_id); end
            @(posedge clk); @(negedge clk);
            req[1] = 1'b0;
        end
        grant_one(seen, id, ad);
        checks++; if (id !== 4'h3 || ad !== 64'hC100) begin errors++; $display("FAIL lock_grant0: got id=%h addr=%h", id, ad); end
        grant_one(seen, id, ad);
        checks++; if (id !== 4'hE || ad !== 64'hD100) begin errors++; $display("FAIL lock_grant1: got id=%h addr=%h", id, ad); end
    endtask

    task automatic test_max_outstanding();
        logic a, seen, rl; logic [3:0] id; logic [63:0] ad, rdat; logic [1:0] rv; logic [2:0] rt;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            pulse_req(0, 64'hE000 + 64'(i * 64), 3'(i), 2'd0, a);
            grant_one(seen, id, ad);
            checks++; if (a !== 1'b1 || id !== {1'b0, 3'(i)})
                begin errors++; $display("FAIL max_fill[%0d]: got ack=%b id=%h", i, a, id); end
        end
        set_fields(0, 64'hE500, 3'd7, 2'd0);
        set_fields(1, 64'hF000, 3'd2, 2'd0);
        req = 2'b11;
        #1;
        checks++; if (ack !== 2'b10) begin errors++; $display("FAIL max_ack_gate: got %b want 10", ack); end
        @(posedge clk); @(negedge clk);
        req[1] = 1'b0;
        grant_one(seen, id, ad);
        checks++; if (seen !== 1'b1 || id !== 4'hA) begin errors++; $display("FAIL max_p1_issue: got req=%b id=%h want 1/a", seen, id); end
        checks++; if (ack[0] !== 1'b0) begin errors++; $display("FAIL max_p0_still_blocked: got %b want 0", ack[0]); end
        send_beat(4'h0, 1'b1, 64'h0, rv, rt, rl, rdat);
        checks++; if (rv !== 2'b01) begin errors++; $display("FAIL max_return: got %b want 01", rv); end
        #1;
        checks++; if (ack[0] !== 1'b1) begin errors++; $display("FAIL max_ack_resume: got %b want 1", ack[0]); end
        @(posedge clk); @(negedge clk);
        req[0] = 1'b0;
        grant_one(seen, id, ad);
        checks++; if (id !== 4'h7 || ad !== 64'hE500) begin errors++; $display("FAIL max_resume_issue: got id=%h addr=%h", id, ad); end
    endtask

    task automatic test_grant_last_same();
        logic a, seen, rl; logic [3:0] id; logic [63:0] ad, rdat; logic [1:0] rv; logic [2:0] rt;
        do_reset();
        pulse_req(1, 64'h1000, 3'd6, 2'd0, a);
        grant_one(seen, id, ad);
        pulse_req(1, 64'h1100, 3'd6, 2'd0, a);
        rd_gnt = 1'b1; rd_valid = 1'b1; rd_id_in = 4'hE; rd_last = 1'b1;
        #1;
        checks++; if (rd_req !== 1'b1 || rtrn_valid !== 2'b10)
            begin errors++; $display("FAIL gl_same_cycle: got req=%b rv=%b want 1/10", rd_req, rtrn_valid); end
        @(posedge clk); @(negedge clk);
        idle_inputs();
        // one burst still in flight: exactly three more fit
        for (int i = 0; i < 3; i++) begin
            pulse_req(1, 64'h1200 + 64'(i), 3'd6, 2'd0, a);
            grant_one(seen, id, ad);
            checks++; if (a !== 1'b1) begin errors++; $display("FAIL gl_refill[%0d]: got ack=%b want 1", i, a); end
        end
        req[1] = 1'b1;
        #1;
        checks++; if (ack[1] !== 1'b0) begin errors++; $display("FAIL gl_count_full: got ack=%b want 0", ack[1]); end
        req[1] = 1'b0;
        @(negedge clk);
        pulse_req(0, 64'h2000, 3'd3, 2'd1, a);
        grant_one(seen, id, ad);
        checks++; if (id !== 4'h3) begin errors++; $display("FAIL gl_p0_id: got %h want 3", id); end
        send_beat(4'h3, 1'b0, 64'hAA, rv, rt, rl, rdat);
        checks++; if (rv !== 2'b01 || rt !== 3'd3) begin errors++; $display("FAIL gl_ooo_a: got rv=%b tid=%0d want 01/3", rv, rt); end
        send_beat(4'hE, 1'b1, 64'hBB, rv, rt, rl, rdat);
        checks++; if (rv !== 2'b10 || rt !== 3'd6) begin errors++; $display("FAIL gl_ooo_b: got rv=%b tid=%0d want 10/6", rv, rt); end
        send_beat(4'h3, 1'b1, 64'hCC, rv, rt, rl, rdat);
        checks++; if (rv !== 2'b01 || rl !== 1'b1) begin errors++; $display("FAIL gl_ooo_c: got rv=%b last=%b want 01/1", rv, rl); end
        pulse_req(1, 64'h1300, 3'd6, 2'd0, a);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL gl_ack_after_return: got %b want 1", a); end
    endtask

    task automatic test_error();
        logic a, seen, rl; logic [3:0] id; logic [63:0] ad, rdat; logic [1:0] rv; logic [2:0] rt;
        do_reset();
        send_beat(4'h8, 1'b1, 64'h0, rv, rt, rl, rdat);
        checks++; if (rv !== 2'b00) begin errors++; $display("FAIL err_drop: got rv=%b want 00", rv); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", err); end
        repeat (3) @(negedge clk);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err); end
        pulse_req(0, 64'h3000, 3'd2, 2'd1, a);
        grant_one(seen, id, ad);
        send_beat(4'h2, 1'b0, 64'h0, rv, rt, rl, rdat);
        checks++; if (rv !== 2'b01) begin errors++; $display("FAIL err_midburst_beat: got %b want 01", rv); end
        pulse_req(1, 64'h3100, 3'd0, 2'd0, a);
        checks++; if (rd_req !== 1'b1) begin errors++; $display("FAIL err_pre_reset_req: got %b want 1", rd_req); end
        idle_inputs();
        rst_n = 1'b0;
        #1;
        checks++; if (rd_req !== 1'b0 || ack !== 2'b00 || rtrn_valid !== 2'b00 || err !== 1'b0)
            begin errors++; $display("FAIL err_async_reset: got req=%b ack=%b rv=%b err=%b want all 0", rd_req, ack, rtrn_valid, err); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_beat(4'h2, 1'b1, 64'h0, rv, rt, rl, rdat);
        checks++; if (rv !== 2'b00 || err !== 1'b1)
            begin errors++; $display("FAIL err_stale_beat: got rv=%b err=%b want 00/1", rv, err); end
    endtask

    // ---------------- randomized test against a reference model ----------------
    typedef struct {
        int          port;
        logic [2:0]  btid;
        int          left;
    } burst_t;

    task automatic test_random();
        int m_pend[2], m_outst[2], m_rr, m_offer, esel, bp, head, pick;
        logic [63:0] m_addr[2];
        logic [2:0]  m_tid[2];
        logic [1:0]  m_blen[2], m_size[2];
        logic [1:0]  exp_ack, exp_rv;
        logic        exp_req, granted;
        logic [1:0]  hold;
        burst_t      bursts[$];
        do_reset();
        for (int p = 0; p < 2; p++) begin
            m_pend[p] = 0; m_outst[p] = 0; m_addr[p] = '0; m_tid[p] = '0; m_blen[p] = '0; m_size[p] = '0;
        end
        m_rr = 0; m_offer = -1; hold = '0; bp = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            // stimulus: unaccepted requests are held unchanged
            for (int p = 0; p < 2; p++) begin
                if (!hold[p]) begin
                    req[p] = ($urandom_range(0, 3) == 0);
                    set_fields(p, {$urandom(), $urandom()}, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
                    size[p*2 +: 2] = 2'($urandom_range(0, 3));
                end
            end
            rd_gnt = 1'($urandom_range(0, 1));
            rd_valid = 1'b0; rd_last = 1'b0;
            head = -1;
            if (bursts.size() > 0 && $urandom_range(0, 1) == 1) begin
                pick = $urandom_range(0, bursts.size() - 1);
                bp = bursts[pick].port;
                for (int j = bursts.size() - 1; j >= 0; j--) if (bursts[j].port == bp) head = j;
                rd_valid  = 1'b1;
                rd_id_in  = {bp == 1, bursts[head].btid};
                rd_last   = (bursts[head].left == 1);
                rd_data   = {$urandom(), $urandom()};
                rd_exokay = 1'($urandom_range(0, 1));
            end
            #1;
            // model outputs
            for (int p = 0; p < 2; p++) exp_ack[p] = req[p] && (m_pend[p] == 0) && (m_outst[p] < 4);
            exp_req = (m_pend[0] != 0) || (m_pend[1] != 0);
            esel = m_offer;
            if (esel < 0) begin
                for (int k = 1; k >= 0; k--) if (m_pend[(m_rr + k) % 2] != 0) esel = (m_rr + k) % 2;
            end
            exp_rv = '0;
            if (rd_valid && m_outst[bp] > 0) exp_rv[bp] = 1'b1;
            checks++; if (ack !== exp_ack) begin errors++; $display("FAIL rnd_ack @%0d: got %b want %b", cyc, ack, exp_ack); end
            checks++; if (rd_req !== exp_req) begin errors++; $display("FAIL rnd_rd_req @%0d: got %b want %b", cyc, rd_req, exp_req); end
            if (exp_req) begin
                checks++;
                if (rd_addr !== m_addr[esel] || rd_id !== {esel == 1, m_tid[esel]} ||
                    rd_blen !== m_blen[esel] || rd_size !== m_size[esel])
                    begin errors++; $display("FAIL rnd_fields @%0d: got addr=%h id=%h blen=%0d size=%0d want addr=%h id=%h blen=%0d size=%0d",
                        cyc, rd_addr, rd_id, rd_blen, rd_size, m_addr[esel], {esel == 1, m_tid[esel]}, m_blen[esel], m_size[esel]); end
            end
            checks++; if (rtrn_valid !== exp_rv) begin errors++; $display("FAIL rnd_rtrn_valid @%0d: got %b want %b", cyc, rtrn_valid, exp_rv); end
            if (rd_valid) begin
                checks++;
                if (rtrn_data !== rd_data || rtrn_tid !== rd_id_in[2:0] || rtrn_last !== rd_last || rtrn_exokay !== rd_exokay)
                    begin errors++; $display("FAIL rnd_passthru @%0d: got data=%h tid=%0d last=%b", cyc, rtrn_data, rtrn_tid, rtrn_last); end
            end
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL rnd_err @%0d: got %b want 0", cyc, err); end
            @(posedge clk);
            // model state update
            granted = exp_req && rd_gnt;
            if (rd_valid) begin
                if (rd_last) m_outst[bp]--;
                bursts[head].left--;
                if (bursts[head].left == 0) bursts.delete(head);
            end
            if (granted) begin
                m_pend[esel] = 0;
                m_outst[esel]++;
                m_rr = (esel + 1) % 2;
                m_offer = -1;
                bursts.push_back('{port: esel, btid: m_tid[esel], left: int'(m_blen[esel]) + 1});
            end else if (exp_req) begin
                m_offer = esel;
            end
            for (int p = 0; p < 2; p++) begin
                if (exp_ack[p]) begin
                    m_pend[p] = 1;
                    m_addr[p] = addr[p*64 +: 64];
                    m_tid[p]  = tid[p*3 +: 3];
                    m_blen[p] = blen[p*2 +: 2];
                    m_size[p] = size[p*2 +: 2];
                end
                hold[p] = req[p] && !exp_ack[p];
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        idle_inputs();
        addr = '0; blen = '0; size = '0; tid = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_max_outstanding();
        test_grant_last_same();
        test_error();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
